audio_sample_arbiter: RTL and testbench
=======================================

# audio_sample_arbiter

Two-requester arbiter that shares one sign/zero-extension datapath between the left and right audio sample sources and delivers width-extended samples, tagged with their channel, to a single downstream consumer. It sits between the per-channel codec deserialisers and the audio processing pipeline. It provides round-robin or strict L/R alternation arbitration, valid/ready handshakes on every port, and a one-entry registered output stage.

## Interface
- `S_WD`, default 16, input sample width.
- `L_WD`, default 24, output sample width. Must satisfy `L_WD > S_WD`; elaboration error otherwise.
- `clk_i`, input, 1, clock.
- `rst_i`, input, 1, reset. Synchronous, active-high.
- `l_valid_i`, input, 1, left sample available.
- `l_data_i`, input, `S_WD`, left sample.
- `l_ready_o`, output, 1, left sample accepted this cycle when high together with `l_valid_i`.
- `r_valid_i`, input, 1, right sample available.
- `r_data_i`, input, `S_WD`, right sample.
- `r_ready_o`, output, 1, right sample accepted this cycle when high together with `r_valid_i`.
- `signed_i`, input, 1, extension mode. 1 = sign-extend, 0 = zero-extend. Sampled on the acceptance cycle.
- `alt_i`, input, 1, arbitration mode. 1 = strict L/R alternation, 0 = round-robin.
- `out_valid_o`, output, 1, output sample valid.
- `out_data_o`, output, `L_WD`, extended sample.
- `out_chan_o`, output, 1, channel tag of the output sample. 0 = left, 1 = right.
- `out_ready_i`, input, 1, consumer accepts the output sample.

## Operation
- **Output stage states.** EMPTY when `out_valid_o` = 0; FULL when `out_valid_o` = 1.
- **Space available.** `can_take = ~out_valid_o | out_ready_i`, i.e. the output is empty or is being drained this cycle.
- **Priority pointer `pri`.** Values LEFT/RIGHT; reset value LEFT.
- **Round-robin (`alt_i` = 0).**
  - Only one channel valid: grant that channel.
  - Both channels valid: grant the channel `pri` points to.
  - After each acceptance, `pri` moves to the channel that was not granted.
- **Strict alternation (`alt_i` = 1).**
  - Grant only the channel `pri` points to.
  - The other channel waits, even if the output is idle.
  - After each acceptance, `pri` toggles.
- **Ready outputs.** `l_ready_o = can_take & grant_l`; `r_ready_o = can_take & grant_r`. At most one is high in any cycle. Both are combinational from valids, `pri`, `alt_i`, `out_valid_o` and `out_ready_i`.
- **Acceptance.** `out_data_o` is loaded with `{L_WD-S_WD` extension bits, sample`}`:
  - the extension bits replicate sample bit `S_WD-1` when `signed_i` = 1;
  - they are zeros when `signed_i` = 0.
  - `out_chan_o` is loaded with the granted channel, and `out_valid_o` is set.
- **Drain without acceptance.** `out_valid_o` clears; `out_data_o` and `out_chan_o` hold their values.
- **Stall.** While FULL and `out_ready_i` = 0, `out_data_o` and `out_chan_o` are stable. No ready output asserts.
- **Mode change.** Toggling `alt_i` mid-stream does not reset `pri`; the new mode applies from that cycle.

## Timing
- **Reset values.** `out_valid_o` = 0, `out_data_o` = 0, `out_chan_o` = 0, `pri` = LEFT.
  - `l_ready_o` and `r_ready_o` evaluate high from the first post-reset cycle if the corresponding valid is asserted.
- **Latency.** One cycle: a sample accepted on cycle N appears on `out_*` on cycle N+1.
- **Throughput.** One sample per cycle while `out_ready_i` is held high. In round-robin with both channels valid the output sequence is L, R, L, R, …
- **Simultaneous drain and accept.** The new sample replaces the old one in the same cycle; `out_valid_o` stays high with no bubble.
- **Reset during operation.** Reset overrides everything. Any held sample is discarded and `pri` returns to LEFT.
  - No ready output asserts during a reset cycle.
- **Valid/ready rules.**
  - Inputs must hold data stable while valid and not yet accepted.
  - `out_valid_o` never drops without `out_ready_i` being high.

## Structure
- **Package `audio_arb_pkg`.**
  - `chan_e` enum: `CH_L` = 1'b0, `CH_R` = 1'b1.
  - Localparam defaults for `S_WD` / `L_WD`.
- **Sub-module.** Instantiate the team's existing combinational `signed_data_extend` once, on the multiplexed granted sample. Its `signed_i` connects directly.
- **Remaining logic.** The grant logic, `pri` register and output register stay in the top module, which is about 150 lines.

## Test plan
- **Sign extension on left.** Reset, then left only with `l_data_i` = 16'h8001 and `signed_i` = 1.
  - Next cycle: `out_data_o` = 24'hFF8001, `out_chan_o` = 0.
  - Repeat with `signed_i` = 0: `out_data_o` = 24'h008001.
- **Round-robin, both valid.** Both channels continuously valid, `alt_i` = 0, `out_ready_i` = 1.
  - `out_chan_o` sequence is 0, 1, 0, 1 over four consecutive cycles, with `out_valid_o` high every cycle after the first.
- **Strict alternation, right only.** `alt_i` = 1, only right valid after reset.
  - `r_ready_o` stays 0 until left presents a sample.
  - After that, left is accepted, then right.
- **Backpressure.** Accept left 16'h1234 (`signed_i` = 0), then hold `out_ready_i` = 0 for 5 cycles.
  - `out_data_o` holds 24'h001234 for those cycles, and both ready outputs stay 0.
  - On release, the pending right sample follows on the next cycle with no bubble.
- **Reset with a held sample.** Assert `rst_i` while FULL and stalled.
  - Next cycle: `out_valid_o` = 0, `out_data_o` = 0, `out_chan_o` = 0.
  - With both channels then valid, the first grant is left.

Source files
------------

// File: rtl/audio_arb_pkg.sv
// Shared types and width defaults for the left/right audio sample arbiter.
package audio_arb_pkg;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_e;

  localparam int unsigned S_WD_DEF = 16;
  localparam int unsigned L_WD_DEF = 24;

endpackage

// File: rtl/signed_data_extend.sv
// Combinational sign/zero extension of an S_WD-bit value to L_WD bits.
module signed_data_extend #(
  parameter int unsigned S_WD = 16,
  parameter int unsigned L_WD = 24
) (
  input  logic [S_WD-1:0] data_i,
  input  logic            signed_i,
  output logic [L_WD-1:0] data_o
);

  logic ext_bit;

  assign ext_bit = signed_i & data_i[S_WD-1];
  assign data_o  = {{(L_WD-S_WD){ext_bit}}, data_i};

endmodule

// File: rtl/audio_sample_arbiter.sv
// Shares one extension datapath between left/right sample sources and delivers
// channel-tagged, width-extended samples through a one-entry output register.
//
// state | meaning
// EMPTY | out_valid_o = 0, output register may be loaded
// FULL  | out_valid_o = 1, holds a sample until out_ready_i
module audio_sample_arbiter
  import audio_arb_pkg::*;
#(
  parameter int unsigned S_WD = S_WD_DEF,
  parameter int unsigned L_WD = L_WD_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            l_valid_i,
  input  logic [S_WD-1:0] l_data_i,
  output logic            l_ready_o,
  input  logic            r_valid_i,
  input  logic [S_WD-1:0] r_data_i,
  output logic            r_ready_o,
  input  logic            signed_i,
  input  logic            alt_i,
  output logic            out_valid_o,
  output logic [L_WD-1:0] out_data_o,
  output logic            out_chan_o,
  input  logic            out_ready_i
);

  if (L_WD <= S_WD) begin : g_width_check
    $error("audio_sample_arbiter: L_WD must be greater than S_WD");
  end

  chan_e           pri_q, pri_d;
  chan_e           chan_q, chan_d;
  logic            valid_q, valid_d;
  logic [L_WD-1:0] data_q, data_d;

  logic            grant_l, grant_r;
  logic            can_take;
  logic            accept;
  logic [S_WD-1:0] sel_data;
  logic [L_WD-1:0] ext_data;

  always_comb begin
    grant_l = 1'b0;
    grant_r = 1'b0;
    if (alt_i) begin
      // Strict alternation: the non-pointed channel waits even if idle.
      grant_l = l_valid_i && (pri_q == CH_L);
      grant_r = r_valid_i && (pri_q == CH_R);
    end else if (l_valid_i && r_valid_i) begin
      grant_l = (pri_q == CH_L);
      grant_r = (pri_q == CH_R);
    end else begin
      grant_l = l_valid_i;
      grant_r = r_valid_i;
    end
  end

  assign can_take  = ~valid_q | out_ready_i;
  assign l_ready_o = can_take & grant_l & ~rst_i;
  assign r_ready_o = can_take & grant_r & ~rst_i;
  assign accept    = l_ready_o | r_ready_o;
  assign sel_data  = grant_r ? r_data_i : l_data_i;

  signed_data_extend #(
    .S_WD (S_WD),
    .L_WD (L_WD)
  ) u_extend (
    .data_i   (sel_data),
    .signed_i (signed_i),
    .data_o   (ext_data)
  );

  always_comb begin
    pri_d   = pri_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      // Pointer always moves to the channel not granted; in alternation mode
      // the granted channel equals pri_q, so this is a toggle.
      pri_d   = grant_r ? CH_L : CH_R;
      chan_d  = grant_r ? CH_R : CH_L;
      data_d  = ext_data;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pri_q   <= CH_L;
      chan_q  <= CH_L;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      pri_q   <= pri_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_chan_o  = chan_q;

endmodule

// File: tb/tb_audio_sample_arbiter.sv
// Directed and randomized checks of audio_sample_arbiter against a behavioural model.
module tb_audio_sample_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        l_valid_i = 1'b0;
  logic [15:0] l_data_i = '0;
  logic        l_ready_o;
  logic        r_valid_i = 1'b0;
  logic [15:0] r_data_i = '0;
  logic        r_ready_o;
  logic        signed_i = 1'b0;
  logic        alt_i = 1'b0;
  logic        out_valid_o;
  logic [23:0] out_data_o;
  logic        out_chan_o;
  logic        out_ready_i = 1'b1;

  int tests = 0;
  int fails = 0;

  // Behavioural model: priority pointer (0 = left) and output holding slot
  bit        m_pri = 1'b0;
  bit        m_full = 1'b0;
  bit [23:0] m_data = '0;
  bit        m_chan = 1'b0;
  bit        m_gl, m_gr;

  always #5 clk_i = ~clk_i;

  audio_sample_arbiter #(.S_WD(16), .L_WD(24)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .l_valid_i   (l_valid_i),
    .l_data_i    (l_data_i),
    .l_ready_o   (l_ready_o),
    .r_valid_i   (r_valid_i),
    .r_data_i    (r_data_i),
    .r_ready_o   (r_ready_o),
    .signed_i    (signed_i),
    .alt_i       (alt_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_chan_o  (out_chan_o),
    .out_ready_i (out_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [23:0] extend(input bit [15:0] d, input bit sg);
    return sg ? 24'($signed(d)) : 24'(d);
  endfunction

  // One clock: drive inputs, check readies before the edge, advance model, check outputs.
  task automatic cycle(input logic rst, input logic lv, input logic [15:0] ld,
                       input logic rv, input logic [15:0] rd,
                       input logic sg, input logic alt, input logic ordy);
    bit space;
    rst_i = rst; l_valid_i = lv; l_data_i = ld; r_valid_i = rv; r_data_i = rd;
    signed_i = sg; alt_i = alt; out_ready_i = ordy;
    #1;
    space = !m_full || ordy;
    m_gl = 1'b0;
    m_gr = 1'b0;
    if (!rst && space) begin
      if (alt) begin
        m_gl = lv && !m_pri;
        m_gr = rv && m_pri;
      end else if (lv && rv) begin
        m_gl = !m_pri;
        m_gr = m_pri;
      end else begin
        m_gl = lv;
        m_gr = rv;
      end
    end
    chk("l_ready", l_ready_o, m_gl);
    chk("r_ready", r_ready_o, m_gr);
    @(posedge clk_i);
    if (rst) begin
      m_pri = 0; m_full = 0; m_data = '0; m_chan = 0;
    end else if (m_gl || m_gr) begin
      m_data = extend(m_gr ? rd : ld, sg);
      m_chan = m_gr;
      m_pri  = !m_gr;
      m_full = 1;
    end else if (ordy) begin
      m_full = 0;
    end
    #1;
    chk("out_valid", out_valid_o, m_full);
    chk("out_data", out_data_o, m_data);
    chk("out_chan", out_chan_o, m_chan);
  endtask

  initial begin
    bit        lv, rv, ordy, alt, sg;
    bit [15:0] ld, rd;

    // reset
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 16'h1111, 1, 16'h2222, 0, 0, 1);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_chan", out_chan_o, 0);

    // sign extension on left
    cycle(0, 1, 16'h8001, 0, 0, 1, 0, 1);
    chk("sext_data", out_data_o, 24'hFF8001);
    chk("sext_chan", out_chan_o, 0);
    cycle(0, 1, 16'h8001, 0, 0, 0, 0, 1);
    chk("zext_data", out_data_o, 24'h008001);

    // round-robin, both valid
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 16'h0100 + 16'(i), 1, 16'h0200 + 16'(i), 0, 0, 1);
      chk("rr_chan", out_chan_o, i % 2);
      chk("rr_valid", out_valid_o, 1);
    end

    // strict alternation, right only
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 16'h0777, 0, 1, 1);
      chk("alt_r_wait", out_valid_o, 0);
    end
    cycle(0, 1, 16'h0555, 1, 16'h0777, 0, 1, 1);
    chk("alt_first_chan", out_chan_o, 0);
    cycle(0, 0, 0, 1, 16'h0777, 0, 1, 1);
    chk("alt_second_chan", out_chan_o, 1);
    chk("alt_second_data", out_data_o, 24'h000777);

    // backpressure
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 16'h1234, 1, 16'h4321, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 16'h4321, 0, 0, 0);
      chk("bp_hold", out_data_o, 24'h001234);
    end
    cycle(0, 0, 0, 1, 16'h4321, 0, 0, 1);
    chk("bp_release_valid", out_valid_o, 1);
    chk("bp_release_chan", out_chan_o, 1);
    chk("bp_release_data", out_data_o, 24'h004321);

    // reset with a held sample (pointer left at RIGHT beforehand)
    cycle(0, 1, 16'h0ABC, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 16'h0DEF, 0, 0, 0);
    cycle(1, 0, 0, 1, 16'h0DEF, 0, 0, 0);
    chk("rst_held_valid", out_valid_o, 0);
    chk("rst_held_data", out_data_o, 0);
    chk("rst_held_chan", out_chan_o, 0);
    cycle(0, 1, 16'h0011, 1, 16'h0022, 0, 0, 1);
    chk("rst_first_grant", out_chan_o, 0);

    // randomized traffic; sources hold their sample until accepted
    lv = 0; rv = 0; ld = 0; rd = 0; alt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!lv) begin lv = ($urandom_range(0, 2) != 0); ld = 16'($urandom); end
      if (!rv) begin rv = ($urandom_range(0, 2) != 0); rd = 16'($urandom); end
      if ($urandom_range(0, 15) == 0) alt = !alt;
      ordy = ($urandom_range(0, 3) != 0);
      sg   = 1'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        cycle(1, lv, ld, rv, rd, sg, alt, ordy);
      end else begin
        cycle(0, lv, ld, rv, rd, sg, alt, ordy);
        if (m_gl) lv = 0;
        if (m_gr) rv = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
